// File: rtl/arm7tdmi_pkg.sv
// Shared types for the ARM7TDMI coprocessor interface: instruction codes, responder FSM
// states and the CDP opcode set with its datapath helper.
package arm7tdmi_pkg;

  typedef enum logic [2:0] {
    CP_CDP = 3'd0,
    CP_LDC = 3'd1,
    CP_STC = 3'd2,
    CP_MCR = 3'd3,
    CP_MRC = 3'd4
  } cp_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StWbeat,
    StRbeat,
    StDone
  } cp_state_t;

  localparam logic [1:0] CDP_ADD = 2'd0;
  localparam logic [1:0] CDP_SUB = 2'd1;
  localparam logic [1:0] CDP_EOR = 2'd2;
  localparam logic [1:0] CDP_CLR = 2'd3;

  function automatic logic [31:0] cdp_alu(input logic [1:0] opc, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] res;
    unique case (opc)
      CDP_ADD: res = a + b;
      CDP_SUB: res = a - b;
      CDP_EOR: res = a ^ b;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/arm7tdmi_cp_regfile.sv
// 16x32 coprocessor register file: one write port, two asynchronous read ports.
// c0 is a read-only identification register.
module arm7tdmi_cp_regfile #(
  parameter logic [31:0] ID_VALUE = 32'h4107_7000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [3:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [3:0]  raddr_b_i,
  output logic [31:0] rdata_b_o
);

  logic [31:0] regs_q [16];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 4'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = (raddr_a_i == 4'd0) ? ID_VALUE : regs_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == 4'd0) ? ID_VALUE : regs_q[raddr_b_i];
  end

endmodule

// File: rtl/arm7tdmi_cp_responder.sv
// Coprocessor responder: claims or rejects CDP/LDC/STC/MCR/MRC from the core, executes them
// on a local register file and returns beat data and a completion pulse.
module arm7tdmi_cp_responder #(
  parameter logic [3:0]  CP_NUM      = 4'd7,
  parameter int unsigned CDP_LATENCY = 3,
  parameter logic [31:0] ID_VALUE    = 32'h4107_7000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cp_valid_i,
  input  logic [2:0]  cp_op_i,
  input  logic [3:0]  cp_num_i,
  input  logic [3:0]  cp_opc1_i,
  input  logic [2:0]  cp_opc2_i,
  input  logic [3:0]  cp_crn_i,
  input  logic [3:0]  cp_crm_i,
  input  logic [3:0]  cp_crd_i,
  input  logic        cp_long_i,
  input  logic [31:0] cp_wdata_i,
  input  logic        cp_wvalid_i,
  input  logic        cp_rready_i,
  output logic        cp_accept_o,
  output logic        cp_undef_o,
  output logic        cp_busy_o,
  output logic [31:0] cp_rdata_o,
  output logic        cp_rvalid_o,
  output logic        cp_last_o,
  output logic        cp_done_o
);
  import arm7tdmi_pkg::*;

  localparam int unsigned LatW = (CDP_LATENCY > 1) ? $clog2(CDP_LATENCY) : 1;

  cp_state_t   state_q, state_d;
  cp_op_t      op_q;
  cp_op_t      op_in;
  logic [3:0]  crn_q, crd_q;
  logic        long_q;
  logic [1:0]  beat_q;
  logic [LatW-1:0] lat_q;
  logic [31:0] res_q;
  logic        accept_q, undef_q;

  logic        sample, reject, beat_last;
  logic [3:0]  rd_idx;
  logic        rf_we;
  logic [3:0]  rf_waddr, rf_raddr_a;
  logic [31:0] rf_wdata, rf_rdata_a, rf_rdata_b;

  // opcode2 is reserved and has no effect
  logic unused_opc2;
  assign unused_opc2 = ^cp_opc2_i;

  assign op_in = cp_op_t'(cp_op_i);
  // Block resampling while the CPU still holds cp_valid in the undef cycle.
  assign sample = (state_q == StIdle) && cp_valid_i && !undef_q;
  assign reject = (cp_num_i != CP_NUM) || (cp_op_i > 3'd4) ||
                  ((op_in == CP_CDP) && (cp_opc1_i > 4'd3));
  assign beat_last = (op_q == CP_MRC || !long_q) ? 1'b1 : (beat_q == 2'd3);
  assign rd_idx = (op_q == CP_MRC) ? crn_q : crd_q + {2'b00, beat_q};
  assign rf_raddr_a = (state_q == StIdle) ? cp_crn_i : rd_idx;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (sample && !reject && (op_in == CP_MCR)) begin
      rf_we    = 1'b1;
      rf_waddr = cp_crn_i;
      rf_wdata = cp_wdata_i;
    end else if ((state_q == StExec) && (lat_q == '0)) begin
      rf_we    = 1'b1;
      rf_waddr = crd_q;
      rf_wdata = res_q;
    end else if ((state_q == StWbeat) && cp_wvalid_i) begin
      rf_we    = 1'b1;
      rf_waddr = rd_idx;
      rf_wdata = cp_wdata_i;
    end
  end

  arm7tdmi_cp_regfile #(
    .ID_VALUE(ID_VALUE)
  ) u_regfile (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .raddr_a_i(rf_raddr_a),
    .rdata_a_o(rf_rdata_a),
    .raddr_b_i(cp_crm_i),
    .rdata_b_o(rf_rdata_b)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (sample && !reject) begin
          case (op_in)
            CP_MCR:  state_d = StDone;
            CP_CDP:  state_d = StExec;
            CP_LDC:  state_d = StWbeat;
            default: state_d = StRbeat;
          endcase
        end
      end
      StExec:  if (lat_q == '0) state_d = StDone;
      StWbeat: if (cp_wvalid_i && beat_last) state_d = StDone;
      StRbeat: if (cp_rready_i && beat_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= CP_CDP;
      crn_q    <= '0;
      crd_q    <= '0;
      long_q   <= 1'b0;
      beat_q   <= '0;
      lat_q    <= '0;
      res_q    <= '0;
      accept_q <= 1'b0;
      undef_q  <= 1'b0;
    end else begin
      accept_q <= sample && !reject;
      undef_q  <= sample && reject;
      if (sample) begin
        op_q   <= op_in;
        crn_q  <= cp_crn_i;
        crd_q  <= cp_crd_i;
        long_q <= cp_long_i;
        beat_q <= '0;
        lat_q  <= LatW'(CDP_LATENCY - 1);
        res_q  <= cdp_alu(cp_opc1_i[1:0], rf_rdata_a, rf_rdata_b);
      end else begin
        if ((state_q == StExec) && (lat_q != '0)) begin
          lat_q <= lat_q - 1'b1;
        end
        if (((state_q == StWbeat) && cp_wvalid_i) || ((state_q == StRbeat) && cp_rready_i)) begin
          beat_q <= beat_q + 2'd1;
        end
      end
    end
  end

  always_comb begin
    cp_accept_o = accept_q;
    cp_undef_o  = undef_q;
    cp_busy_o   = (state_q != StIdle);
    cp_rvalid_o = (state_q == StRbeat);
    cp_last_o   = cp_rvalid_o && beat_last;
    cp_rdata_o  = cp_rvalid_o ? rf_rdata_a : '0;
    cp_done_o   = (state_q == StDone);
  end

endmodule
